// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : shared constants, motion encodings and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int NUM_FLOORS = 5;

  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_OPENING   = 3'd3,
    ST_DWELL     = 3'd4,
    ST_CLOSING   = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // SCAN choice: keep the preferred direction while work lies that way,
  // otherwise turn around, otherwise go idle.
  function automatic state_t pick_dir(input logic pref_up, input logic up, input logic down);
    if (pref_up) return up ? ST_MOVE_UP : (down ? ST_MOVE_DOWN : ST_IDLE);
    else         return down ? ST_MOVE_DOWN : (up ? ST_MOVE_UP : ST_IDLE);
  endfunction

  function automatic logic [1:0] ud_of(input state_t st);
    case (st)
      ST_MOVE_UP:   return UD_UP;
      ST_MOVE_DOWN: return UD_DOWN;
      default:      return UD_STOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_call_latch.sv
// ============================================================================
// elevator_call_latch : pending-call register plus at/above/below request flags
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_call_latch #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [2:0]            i_floor,
  input  logic                  i_clear_at,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_at,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_call_at
);

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_eff;
  logic [NUM_FLOORS-1:0] w_onehot;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    localparam logic [2:0] c_floor_num = 3'(i + 1);
    assign w_onehot[i] = (i_floor == c_floor_num);
    assign w_above[i]  = (i_floor <  c_floor_num);
    assign w_below[i]  = (i_floor >  c_floor_num);
  end

  // Decisions see this cycle's calls too, so a call gets a response one edge later.
  assign w_eff     = r_pending | i_call;
  assign o_at      = |(w_eff & w_onehot);
  assign o_up      = |(w_eff & w_above);
  assign o_down    = |(w_eff & w_below);
  assign o_call_at = |(i_call & w_onehot);
  assign o_pending = r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_eff & ~(w_onehot & {NUM_FLOORS{i_clear_at}});
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_dispatcher.sv
// ============================================================================
// elevator_dispatcher : SCAN elevator controller with door dwell and fault trap
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_dispatcher #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [2:0]            floor,
  input  logic                  door,
  output logic                  door_open,
  output logic [1:0]            updown,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault
);

  import elevator_pkg::*;

  localparam int             CW           = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  c_dwell_last = CW'(DWELL_CYCLES - 1);

  state_t        r_state;
  logic [1:0]    r_updown;
  logic          r_door_open;
  logic          r_fault;
  logic          r_dir_up;
  logic [CW-1:0] r_cnt;

  logic   w_at;
  logic   w_up;
  logic   w_down;
  logic   w_call_at;
  logic   w_clear_at;
  logic   w_floor_ok;
  logic   w_pref_up;
  state_t w_scan;

  assign w_clear_at = ((r_state == ST_OPENING) && door) || (r_state == ST_DWELL);
  assign w_floor_ok = (floor != 3'd0) && (floor <= 3'(NUM_FLOORS));
  assign w_pref_up  = (r_state == ST_MOVE_DOWN) ? 1'b0 :
                      (r_state == ST_CLOSING)   ? r_dir_up : 1'b1;
  assign w_scan     = pick_dir(w_pref_up, w_up, w_down);

  elevator_call_latch #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_call_latch (
    .clk        (clk),
    .rst        (rst),
    .i_call     (call_req),
    .i_floor    (floor),
    .i_clear_at (w_clear_at),
    .o_pending  (pending),
    .o_at       (w_at),
    .o_up       (w_up),
    .o_down     (w_down),
    .o_call_at  (w_call_at)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_updown    <= UD_STOP;
      r_door_open <= 1'b0;
      r_fault     <= 1'b0;
      r_dir_up    <= 1'b1;
      r_cnt       <= '0;
    end else if (!w_floor_ok || (r_state == ST_FAULT)) begin
      r_state     <= ST_FAULT;
      r_updown    <= UD_STOP;
      r_door_open <= 1'b0;
      r_fault     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (w_at) begin
            r_state     <= ST_OPENING;
            r_updown    <= UD_STOP;
            r_door_open <= 1'b1;
          end else begin
            r_state  <= w_scan;
            r_updown <= ud_of(w_scan);
            if (w_scan == ST_MOVE_UP)   r_dir_up <= 1'b1;
            if (w_scan == ST_MOVE_DOWN) r_dir_up <= 1'b0;
          end
        end
        ST_OPENING: begin
          r_updown    <= UD_STOP;
          r_door_open <= 1'b1;
          if (door) begin
            r_state <= ST_DWELL;
            r_cnt   <= '0;
          end
        end
        ST_DWELL: begin
          if (w_call_at) begin
            r_cnt <= '0;
          end else if (r_cnt == c_dwell_last) begin
            r_state     <= ST_CLOSING;
            r_door_open <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CLOSING: begin
          // A call at this floor reopens even if the door already reports closed.
          if (w_at) begin
            r_state     <= ST_OPENING;
            r_door_open <= 1'b1;
          end else if (!door) begin
            r_state  <= w_scan;
            r_updown <= ud_of(w_scan);
            if (w_scan == ST_MOVE_UP)   r_dir_up <= 1'b1;
            if (w_scan == ST_MOVE_DOWN) r_dir_up <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_updown    <= UD_STOP;
          r_door_open <= 1'b0;
        end
      endcase
    end
  end

  assign door_open = r_door_open;
  assign updown    = r_updown;
  assign fault     = r_fault;

endmodule

`default_nettype wire

// File: doc/elevator_dispatcher.md
ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 Parameter NUM_FLOORS, default 5: number of served floors; the only supported value is 5.
REQ-002 Parameter DWELL_CYCLES, default 4: clk cycles the door is held open after door=1 is first seen.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port call_req, input, 5: per-floor call; bit i=1 requests floor i+1; pulse or level.
REQ-006 Port floor, input, 3: current floor, binary; valid values are 1..5.
REQ-007 Port door, input, 1: door status; 1=open, 0=closed.
REQ-008 Port door_open, output, 1: door command; 1=open/hold open.
REQ-009 Port updown, output, 2: motion command; 00=stop, 01=up, 10=down; 11 is never driven.
REQ-010 Port pending, output, 5: latched, unserved calls; bit i corresponds to floor i+1.
REQ-011 Port fault, output, 1: sticky flag; 1=an invalid floor value was seen.

Function
REQ-012 All outputs SHALL be registered: inputs are sampled on edge N and the response appears after edge N.
REQ-013 Pending register: pending_next = (pending | call_req) & ~served_mask; a call and a service of the same bit in the same cycle SHALL leave the bit clear.
REQ-014 Direction masks: "ahead-up" = pending bits above floor; "ahead-down" = pending bits below floor.
REQ-015 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, OPENING, DWELL, CLOSING and FAULT.
REQ-016 IDLE, outputs 00/0:
- pending[floor] set -> OPENING;
- else ahead-up nonzero -> MOVE_UP;
- else ahead-down nonzero -> MOVE_DOWN;
- else stay in IDLE.
REQ-017 MOVE_UP, updown=01; MOVE_DOWN, updown=10:
- hold the command until pending[floor] is set, then -> OPENING with updown=00;
- if there is no request ahead or at the current floor: reverse direction if requests exist behind, else -> IDLE.
REQ-018 At floor=5 updown SHALL NOT be 01; at floor=1 updown SHALL NOT be 10.
REQ-019 OPENING: door_open=1 and updown=00; stay until door=1 is sampled, then -> DWELL.
REQ-020 DWELL: door_open=1; clear pending[floor] on entry; count DWELL_CYCLES cycles, then -> CLOSING.
REQ-021 A call_req for the current floor during DWELL SHALL be cleared and SHALL restart the dwell count.
REQ-022 CLOSING: door_open=0; wait until door=0 is sampled, then select the next direction:
- continue the previous direction if requests exist ahead;
- else reverse if requests exist behind;
- else -> IDLE.
REQ-023 A call_req arriving in CLOSING for the current floor SHALL return the FSM to OPENING.
REQ-024 floor equal to 0, 6 or 7 in any state SHALL force FAULT: updown=00, door_open=0, fault=1; FAULT exits only on rst; pending keeps latching calls.
REQ-025 Simultaneous calls on several floors SHALL all latch in the same cycle; service order follows REQ-016/REQ-017 (SCAN).

Reset
REQ-026 While rst=1 at an edge: state=IDLE, pending=0, updown=00, door_open=0, fault=0, dwell counter=0.
REQ-027 Reset mid-motion or mid-dwell SHALL discard all pending calls; call_req sampled in the rst cycle SHALL be ignored.

Structure
REQ-028 Package elevator_pkg SHALL hold the NUM_FLOORS constant, the UD_STOP/UD_UP/UD_DOWN encodings and the FSM state enumeration.
REQ-029 One sub-module, elevator_call_latch, SHALL implement the pending register and the ahead-up/ahead-down masks; the FSM and the dwell counter stay in the top module.

Verification
REQ-030 Reset, then call_req=00100 pulse with floor=1, door=0 -> updown=01 the next cycle; hold floor=2 -> still 01; floor=3 -> updown=00, door_open=1.
REQ-031 At floor=3 in OPENING, drive door=1 -> pending bit 2 clears; door_open stays 1 for 4 cycles, then drops to 0; door=0 with pending=0 -> IDLE with 00/0.
REQ-032 At floor=3 moving up, with calls 10000 and 00001 latched -> floor 5 served first, then updown=10 until floor 1.
REQ-033 Call for the current floor at floor=2 in IDLE -> door_open=1 the next cycle with updown=00.
REQ-034 floor=6 injected while in MOVE_UP -> fault=1, updown=00, door_open=0 held until rst=1; rst -> all outputs 0.
REQ-035 rst asserted during DWELL with pending=11010 -> pending=00000, IDLE next cycle, no motion afterwards.
